// File: rtl/issue_queue_scoreboard.sv
// Issue queue with a per-register pending-write scoreboard.
// Decode enqueues entries into a circular buffer; the head entry issues to
// one execute pipe once its sources have no outstanding writers and its
// destination counter is not saturated. Writeback completions retire
// pending writes.
module issue_queue_scoreboard #(
    parameter int p_depth        = 4,
    parameter int p_num_pipes    = 2,
    parameter int p_seq_num_bits = 8,
    parameter int p_cnt_bits     = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_enq_val,
    output logic                           o_enq_rdy,
    input  logic [p_seq_num_bits-1:0]      i_enq_seq_num,
    input  logic [4:0]                     i_enq_rs1,
    input  logic [4:0]                     i_enq_rs2,
    input  logic [4:0]                     i_enq_rd,
    input  logic                           i_enq_rs1_en,
    input  logic                           i_enq_rs2_en,
    input  logic                           i_enq_wen,
    input  logic [p_num_pipes-1:0]         i_enq_pipe_mask,
    output logic [p_num_pipes-1:0]         o_iss_val,
    input  logic [p_num_pipes-1:0]         i_iss_rdy,
    output logic [p_seq_num_bits-1:0]      o_iss_seq_num,
    output logic [4:0]                     o_iss_rd,
    input  logic                           i_cmp_val,
    input  logic                           i_cmp_wen,
    input  logic [4:0]                     i_cmp_rd,
    input  logic                           i_flush,
    output logic [$clog2(p_depth+1)-1:0]   o_occupancy,
    output logic                           o_stall_raw,
    output logic                           o_stall_sat
);

    localparam int lp_ptr_bits = (p_depth > 1) ? $clog2(p_depth) : 1;
    localparam int lp_occ_bits = $clog2(p_depth + 1);

    localparam logic [lp_occ_bits-1:0] lp_full    = lp_occ_bits'(p_depth);
    localparam logic [lp_occ_bits-1:0] lp_occ_one = lp_occ_bits'(1);
    localparam logic [lp_ptr_bits-1:0] lp_last    = lp_ptr_bits'(p_depth - 1);
    localparam logic [lp_ptr_bits-1:0] lp_ptr_one = lp_ptr_bits'(1);
    localparam logic [p_cnt_bits-1:0]  lp_cnt_max = '1;
    localparam logic [p_cnt_bits-1:0]  lp_cnt_one = p_cnt_bits'(1);
    localparam logic [p_num_pipes-1:0] lp_pipe_one = p_num_pipes'(1);

    // Entry storage
    logic [p_seq_num_bits-1:0] r_seq     [p_depth];
    logic [4:0]                r_rs1     [p_depth];
    logic [4:0]                r_rs2     [p_depth];
    logic [4:0]                r_rd      [p_depth];
    logic                      r_rs1_en  [p_depth];
    logic                      r_rs2_en  [p_depth];
    logic                      r_wen     [p_depth];
    logic [p_num_pipes-1:0]    r_mask    [p_depth];

    // Queue bookkeeping
    logic [lp_ptr_bits-1:0]    r_head;
    logic [lp_ptr_bits-1:0]    r_tail;
    logic [lp_occ_bits-1:0]    r_count;

    // Outstanding writes per architectural register (entry 0 stays zero)
    logic [p_cnt_bits-1:0]     r_cnt [32];

    logic [4:0]                w_head_rs1;
    logic [4:0]                w_head_rs2;
    logic [4:0]                w_head_rd;
    logic                      w_head_rs1_en;
    logic                      w_head_rs2_en;
    logic                      w_head_wen;
    logic [p_num_pipes-1:0]    w_head_mask;
    logic                      w_head_valid;
    logic                      w_raw_rs1;
    logic                      w_raw_rs2;
    logic [p_num_pipes-1:0]    w_avail;
    logic [p_num_pipes-1:0]    w_avail_low;
    logic [p_num_pipes-1:0]    w_mask_low;
    logic [p_num_pipes-1:0]    w_sel;
    logic                      w_issue_ok;
    logic                      w_iss_fire;
    logic                      w_drop;
    logic                      w_deq;
    logic                      w_enq_fire;
    logic                      w_inc;
    logic                      w_dec;
    logic [31:0]               w_inc_vec;
    logic [31:0]               w_dec_vec;

    assign w_head_rs1    = r_rs1[r_head];
    assign w_head_rs2    = r_rs2[r_head];
    assign w_head_rd     = r_rd[r_head];
    assign w_head_rs1_en = r_rs1_en[r_head];
    assign w_head_rs2_en = r_rs2_en[r_head];
    assign w_head_wen    = r_wen[r_head];
    assign w_head_mask   = r_mask[r_head];
    assign w_head_valid  = (r_count != '0);

    assign w_raw_rs1 = w_head_rs1_en && (w_head_rs1 != 5'd0) && (r_cnt[w_head_rs1] != '0);
    assign w_raw_rs2 = w_head_rs2_en && (w_head_rs2 != 5'd0) && (r_cnt[w_head_rs2] != '0);

    assign o_stall_raw = w_head_valid && (w_raw_rs1 || w_raw_rs2);
    assign o_stall_sat = w_head_valid && w_head_wen && (w_head_rd != 5'd0)
                         && (r_cnt[w_head_rd] == lp_cnt_max);

    // Prefer the lowest ready capable pipe; otherwise wait on the lowest capable one
    assign w_avail     = w_head_mask & i_iss_rdy;
    assign w_avail_low = w_avail & (~w_avail + lp_pipe_one);
    assign w_mask_low  = w_head_mask & (~w_head_mask + lp_pipe_one);
    assign w_sel       = (w_avail != '0) ? w_avail_low : w_mask_low;

    assign w_issue_ok = w_head_valid && !o_stall_raw && !o_stall_sat && !i_flush
                        && (w_head_mask != '0);
    assign o_iss_val  = w_issue_ok ? w_sel : '0;
    assign w_iss_fire = |(o_iss_val & i_iss_rdy);

    // An entry no pipe can execute is discarded rather than blocking the queue
    assign w_drop = w_head_valid && (w_head_mask == '0) && !i_flush;
    assign w_deq  = w_iss_fire || w_drop;

    assign o_enq_rdy  = (r_count < lp_full) && !i_flush;
    assign w_enq_fire = i_enq_val && o_enq_rdy;

    assign w_inc     = w_iss_fire && w_head_wen && (w_head_rd != 5'd0);
    assign w_dec     = i_cmp_val && i_cmp_wen && (i_cmp_rd != 5'd0);
    assign w_inc_vec = w_inc ? (32'd1 << w_head_rd) : 32'd0;
    assign w_dec_vec = w_dec ? (32'd1 << i_cmp_rd) : 32'd0;

    assign o_iss_seq_num = r_seq[r_head];
    assign o_iss_rd      = w_head_rd;
    assign o_occupancy   = r_count;

    // Advance head/tail pointers and occupancy; flush empties the queue
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq_fire) begin
                r_tail <= (r_tail == lp_last) ? '0 : r_tail + lp_ptr_one;
            end
            if (w_deq) begin
                r_head <= (r_head == lp_last) ? '0 : r_head + lp_ptr_one;
            end
            case ({w_enq_fire, w_deq})
                2'b10:   r_count <= r_count + lp_occ_one;
                2'b01:   r_count <= r_count - lp_occ_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // Capture the accepted entry at the tail slot
    always_ff @(posedge clk) begin
        if (w_enq_fire) begin
            r_seq[r_tail]    <= i_enq_seq_num;
            r_rs1[r_tail]    <= i_enq_rs1;
            r_rs2[r_tail]    <= i_enq_rs2;
            r_rd[r_tail]     <= i_enq_rd;
            r_rs1_en[r_tail] <= i_enq_rs1_en;
            r_rs2_en[r_tail] <= i_enq_rs2_en;
            r_wen[r_tail]    <= i_enq_wen;
            r_mask[r_tail]   <= i_enq_pipe_mask;
        end
    end

    // Count issued writes up and completed writes down; a same-register hit cancels
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                if (w_inc_vec[i] && !w_dec_vec[i] && (r_cnt[i] != lp_cnt_max)) begin
                    r_cnt[i] <= r_cnt[i] + lp_cnt_one;
                end else if (w_dec_vec[i] && !w_inc_vec[i] && (r_cnt[i] != '0)) begin
                    r_cnt[i] <= r_cnt[i] - lp_cnt_one;
                end
            end
        end
    end

endmodule
